// File: rtl/psum_drain_accum.sv
// psum_drain_accum: accumulates K-tile partial sums from the bottom PE of a
// systolic column, requantizes finished sums to 8-bit activations and hands
// results to writeback through a small in-order FIFO.
module psum_drain_accum #(
   parameter int SUM_W = 24,
   parameter int ACC_W = 32,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_cfg_passes,
   input  logic [CNT_W-1:0] i_cfg_count,
   input  logic [4:0]       i_cfg_shift,
   input  logic             i_sum_valid,
   input  logic [SUM_W-1:0] i_sum,
   output logic             o_in_ready,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_valid,
   output logic [ACC_W-1:0] o_data,
   output logic [7:0]       o_act,
   input  logic             i_ready
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] hold_data;
   logic [CNT_W-1:0] pass_cnt;
   logic [CNT_W-1:0] res_cnt;
   logic [CNT_W-1:0] passes_m1;   // last pass index of a result (config 0 -> 1 pass)
   logic [CNT_W-1:0] count_m1;    // last result index of a job (config 0 -> 1 result)
   logic [4:0]       shift;

   logic [ACC_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      occ;

   logic             full;
   logic             pop;
   logic             space;
   logic             accept;
   logic             last_pass;
   logic             last_res;
   logic             push;
   logic [ACC_W-1:0] result;
   logic [ACC_W-1:0] push_data;
   logic [ACC_W-1:0] shifted;

   assign o_busy     = (state != IDLE);
   assign o_in_ready = (state == ACCUM);
   assign o_valid    = (occ != '0);

   assign full      = (occ == (AW+1)'(DEPTH));
   assign pop       = o_valid && i_ready;
   // A full FIFO still has room this cycle if the consumer pops the head.
   assign space     = !full || pop;
   assign accept    = i_sum_valid && o_in_ready;
   assign last_pass = (pass_cnt == passes_m1);
   assign last_res  = (res_cnt == count_m1);
   assign result    = acc + ACC_W'(i_sum);

   // Select what enters the FIFO this cycle: the parked result in HOLD, else a
   // freshly completed sum.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      push      = 1'b0;
      push_data = result;
      if (state == HOLD) begin
         push      = space;
         push_data = hold_data;
      end else if (accept && last_pass) begin
         push = space;
      end
   end

   // Job control FSM: config latch, pass/result counting, hold on backpressure.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         acc       <= '0;
         hold_data <= '0;
         pass_cnt  <= '0;
         res_cnt   <= '0;
         passes_m1 <= '0;
         count_m1  <= '0;
         shift     <= '0;
         o_done    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples the
         // pre-edge values; later assignments in this block override earlier ones.
         o_done <= 1'b0;
         case (state)
            IDLE: begin
               if (i_start) begin
                  passes_m1 <= (i_cfg_passes == '0) ? '0 : i_cfg_passes - CNT_W'(1);
                  count_m1  <= (i_cfg_count == '0) ? '0 : i_cfg_count - CNT_W'(1);
                  shift     <= i_cfg_shift;
                  acc       <= '0;
                  pass_cnt  <= '0;
                  res_cnt   <= '0;
                  state     <= ACCUM;
               end
            end
            ACCUM: begin
               if (accept) begin
                  if (!last_pass) begin
                     acc      <= result;
                     pass_cnt <= pass_cnt + CNT_W'(1);
                  end else begin
                     acc      <= '0;
                     pass_cnt <= '0;
                     if (!space) begin
                        hold_data <= result;
                        state     <= HOLD;
                     end
                  end
               end
            end
            HOLD: begin
               // Waits here until the FIFO frees a slot; the write itself is
               // handled by the common completion step below.
            end
            default: state <= IDLE;
         endcase

         // Completion of one result, shared by ACCUM and HOLD.
         if (push) begin
            if (last_res) begin
               state  <= IDLE;
               o_done <= 1'b1;
            end else begin
               res_cnt <= res_cnt + CNT_W'(1);
               state   <= ACCUM;
            end
         end
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   occ <= occ + (AW+1)'(1);
            2'b01:   occ <= occ - (AW+1)'(1);
            default: occ <= occ;
         endcase
      end
   end

   // FIFO storage.
   always_ff @(posedge clock) begin
      // NOTE: the storage array is deliberately not reset; an entry is only ever
      // read after it has been written, and o_data is forced to 0 while empty.
      if (push) mem[wr_ptr] <= push_data;
   end

   assign o_data  = o_valid ? mem[rd_ptr] : '0;

   // Requantize the head: logical right shift, then unsigned saturate to 8 bits.
   assign shifted = o_data >> shift;
   assign o_act   = (shifted > ACC_W'(255)) ? 8'hFF : shifted[7:0];

endmodule

// File: tb/tb_psum_drain_accum.sv
// Self-checking bench for psum_drain_accum: directed vector table, hand-written
// multi-cycle sequences, and a randomized phase against a job-level model.
module tb_psum_drain_accum;

   localparam int SUM_W = 24;
   localparam int ACC_W = 32;
   localparam int DEPTH = 4;
   localparam int CNT_W = 8;

   logic             clock;
   logic             reset;
   logic             i_start;
   logic [CNT_W-1:0] i_cfg_passes;
   logic [CNT_W-1:0] i_cfg_count;
   logic [4:0]       i_cfg_shift;
   logic             i_sum_valid;
   logic [SUM_W-1:0] i_sum;
   logic             o_in_ready;
   logic             o_busy;
   logic             o_done;
   logic             o_valid;
   logic [ACC_W-1:0] o_data;
   logic [7:0]       o_act;
   logic             i_ready;

   int n_checks;
   int n_errors;

   psum_drain_accum #(
      .SUM_W(SUM_W),
      .ACC_W(ACC_W),
      .DEPTH(DEPTH),
      .CNT_W(CNT_W)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .i_start     (i_start),
      .i_cfg_passes(i_cfg_passes),
      .i_cfg_count (i_cfg_count),
      .i_cfg_shift (i_cfg_shift),
      .i_sum_valid (i_sum_valid),
      .i_sum       (i_sum),
      .o_in_ready  (o_in_ready),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_valid     (o_valid),
      .o_data      (o_data),
      .o_act       (o_act),
      .i_ready     (i_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [7:0]        passes;
      logic [7:0]        count;
      logic [4:0]        shift;
      logic [2:0]        nsums;
      logic [3:0][23:0]  sums;
      logic [31:0]       exp_data;
      logic [7:0]        exp_act;
   } vec_t;

   vec_t vecs [7];

   function automatic vec_t mk_vec(input logic [7:0] p, input logic [7:0] c,
                                   input logic [4:0] sh, input int n,
                                   input logic [23:0] s0, input logic [23:0] s1,
                                   input logic [23:0] s2, input logic [23:0] s3,
                                   input logic [31:0] ed, input logic [7:0] ea);
      vec_t v;
      v.passes   = p;
      v.count    = c;
      v.shift    = sh;
      v.nsums    = 3'(n);
      v.sums[0]  = s0;
      v.sums[1]  = s1;
      v.sums[2]  = s2;
      v.sums[3]  = s3;
      v.exp_data = ed;
      v.exp_act  = ea;
      return v;
   endfunction

   // Requantization rule: logical shift then clamp to 255.
   function automatic logic [7:0] sat_act(input logic [31:0] v, input int sh);
      longint s;
      s = longint'(v) >> sh;
      return (s > 255) ? 8'hFF : 8'(s);
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic start_job(input logic [7:0] p, input logic [7:0] c, input logic [4:0] sh);
      i_start      = 1'b1;
      i_cfg_passes = p;
      i_cfg_count  = c;
      i_cfg_shift  = sh;
      tick();
      i_start = 1'b0;
      check("start_busy", 32'(o_busy), 32'd1);
   endtask

   task automatic feed(input logic [23:0] s);
      check("feed_ready", 32'(o_in_ready), 32'd1);
      i_sum_valid = 1'b1;
      i_sum       = s;
      tick();
      i_sum_valid = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      start_job(v.passes, v.count, v.shift);
      for (int i = 0; i < int'(v.nsums); i++) feed(v.sums[i]);
      check($sformatf("vec%0d_valid", idx), 32'(o_valid), 32'd1);
      check($sformatf("vec%0d_data", idx), o_data, v.exp_data);
      check($sformatf("vec%0d_act", idx), 32'(o_act), 32'(v.exp_act));
      check($sformatf("vec%0d_done", idx), 32'(o_done), 32'd1);
      check($sformatf("vec%0d_busy", idx), 32'(o_busy), 32'd0);
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      check($sformatf("vec%0d_done_clr", idx), 32'(o_done), 32'd0);
      check($sformatf("vec%0d_empty", idx), 32'(o_valid), 32'd0);
   endtask

   logic [23:0] feed_q [$];
   logic [31:0] exp_q  [$];

   initial begin
      int got;
      int dones;
      bit fed;
      int p, c, sh, pe, ce, guard;
      longint tot;
      logic [23:0] s;

      n_checks     = 0;
      n_errors     = 0;
      reset        = 1'b1;
      i_start      = 1'b0;
      i_cfg_passes = '0;
      i_cfg_count  = '0;
      i_cfg_shift  = '0;
      i_sum_valid  = 1'b0;
      i_sum        = '0;
      i_ready      = 1'b0;
      @(negedge clock);

      // Reset held for 3 cycles with random inputs.
      for (int i = 0; i < 3; i++) begin
         i_start      = 1'($urandom);
         i_cfg_passes = 8'($urandom);
         i_cfg_count  = 8'($urandom);
         i_cfg_shift  = 5'($urandom);
         i_sum_valid  = 1'($urandom);
         i_sum        = 24'($urandom);
         i_ready      = 1'($urandom);
         tick();
      end
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_data", o_data, 32'd0);
      check("rst_act", 32'(o_act), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);
      check("rst_in_ready", 32'(o_in_ready), 32'd0);
      reset       = 1'b0;
      i_start     = 1'b0;
      i_sum_valid = 1'b0;
      i_ready     = 1'b0;
      tick();

      // Table-driven single-result jobs.
      vecs[0] = mk_vec(8'd4, 8'd1, 5'd0, 4, 24'd1, 24'd2, 24'd3, 24'd4, 32'd10, 8'd10);
      vecs[1] = mk_vec(8'd2, 8'd1, 5'd0, 2, 24'hFFFFFF, 24'hFFFFFF, 24'd0, 24'd0, 32'h1FFFFFE, 8'd255);
      vecs[2] = mk_vec(8'd2, 8'd1, 5'd17, 2, 24'hFFFFFF, 24'hFFFFFF, 24'd0, 24'd0, 32'h1FFFFFE, 8'd255);
      vecs[3] = mk_vec(8'd2, 8'd1, 5'd25, 2, 24'hFFFFFF, 24'hFFFFFF, 24'd0, 24'd0, 32'h1FFFFFE, 8'd0);
      vecs[4] = mk_vec(8'd0, 8'd0, 5'd0, 1, 24'd5, 24'd0, 24'd0, 24'd0, 32'd5, 8'd5);
      vecs[5] = mk_vec(8'd1, 8'd1, 5'd4, 1, 24'h123, 24'd0, 24'd0, 24'd0, 32'h123, 8'h12);
      vecs[6] = mk_vec(8'd3, 8'd1, 5'd8, 3, 24'h1000, 24'h2000, 24'h0ABC, 24'd0, 32'h3ABC, 8'h3A);
      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      // Backpressure: 4 results fill the FIFO, the 5th parks in HOLD.
      i_ready = 1'b0;
      start_job(8'd1, 8'd6, 5'd0);
      for (int k = 0; k < 5; k++) feed(24'(10 + k));
      check("bp_in_ready", 32'(o_in_ready), 32'd0);
      check("bp_busy", 32'(o_busy), 32'd1);
      tick();
      tick();
      check("bp_hold_ready", 32'(o_in_ready), 32'd0);
      check("bp_head", o_data, 32'd10);
      got   = 0;
      dones = 0;
      fed   = 1'b0;
      i_ready = 1'b1;
      for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
         if (o_done) dones++;
         if (o_in_ready && !fed) begin
            i_sum_valid = 1'b1;
            i_sum       = 24'd15;
            fed         = 1'b1;
         end else begin
            i_sum_valid = 1'b0;
         end
         if (o_valid) begin
            check("bp_out", o_data, 32'(10 + got));
            got++;
         end
         tick();
      end
      i_sum_valid = 1'b0;
      i_ready     = 1'b0;
      if (o_done) dones++;
      check("bp_count", 32'(got), 32'd6);
      check("bp_dones", 32'(dones), 32'd1);
      check("bp_empty", 32'(o_valid), 32'd0);
      check("bp_idle", 32'(o_busy), 32'd0);

      // Reset in the middle of a job discards the partial accumulation.
      start_job(8'd4, 8'd1, 5'd0);
      feed(24'd100);
      feed(24'd200);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mr_busy", 32'(o_busy), 32'd0);
      check("mr_valid", 32'(o_valid), 32'd0);
      start_job(8'd1, 8'd1, 5'd0);
      feed(24'd7);
      check("mr_data", o_data, 32'd7);
      check("mr_done", 32'(o_done), 32'd1);
      i_ready = 1'b1;
      tick();
      tick();
      tick();
      i_ready = 1'b0;
      check("mr_no_300", 32'(o_valid), 32'd0);

      // i_start during ACCUM is ignored and config stays as latched.
      start_job(8'd2, 8'd1, 5'd0);
      feed(24'd3);
      i_start      = 1'b1;
      i_cfg_passes = 8'd1;
      i_cfg_count  = 8'd3;
      i_cfg_shift  = 5'd31;
      tick();
      i_start = 1'b0;
      check("ign_no_result", 32'(o_valid), 32'd0);
      check("ign_busy", 32'(o_busy), 32'd1);
      feed(24'd4);
      check("ign_data", o_data, 32'd7);
      check("ign_act", 32'(o_act), 32'd7);
      check("ign_done", 32'(o_done), 32'd1);
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      check("ign_idle", 32'(o_busy), 32'd0);

      // Randomized jobs against a job-level model: results are group sums of
      // the issued partial sums, delivered in order, one o_done per job.
      for (int j = 0; j < 30; j++) begin
         p  = $urandom_range(0, 5);
         c  = $urandom_range(0, 6);
         sh = $urandom_range(0, 31);
         pe = (p == 0) ? 1 : p;
         ce = (c == 0) ? 1 : c;
         feed_q.delete();
         exp_q.delete();
         for (int r = 0; r < ce; r++) begin
            tot = 0;
            for (int q = 0; q < pe; q++) begin
               s = 24'($urandom >> $urandom_range(8, 28));
               feed_q.push_back(s);
               tot += longint'(s);
            end
            exp_q.push_back(32'(tot));
         end
         i_ready = 1'b0;
         start_job(8'(p), 8'(c), 5'(sh));
         dones = 0;
         guard = 0;
         while ((feed_q.size() > 0 || exp_q.size() > 0 || dones == 0) && guard < 3000) begin
            i_ready     = ($urandom_range(0, 3) != 0);
            i_sum_valid = (feed_q.size() > 0) && ($urandom_range(0, 3) != 0);
            i_sum       = i_sum_valid ? feed_q[0] : 24'($urandom);
            if (o_done) dones++;
            if (o_valid && i_ready) begin
               if (exp_q.size() == 0) begin
                  check("rand_extra_out", 32'(o_valid), 32'd0);
               end else begin
                  check("rand_data", o_data, exp_q[0]);
                  check("rand_act", 32'(o_act), 32'(sat_act(exp_q[0], sh)));
                  void'(exp_q.pop_front());
               end
            end
            if (i_sum_valid && o_in_ready) void'(feed_q.pop_front());
            tick();
            guard++;
         end
         i_sum_valid = 1'b0;
         i_ready     = 1'b0;
         if (o_done) dones++;
         check("rand_no_timeout", 32'(guard < 3000), 32'd1);
         check("rand_dones", 32'(dones), 32'd1);
         check("rand_empty", 32'(o_valid), 32'd0);
         if (guard >= 3000) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
